mult_requester: RTL and testbench

MULT_REQUESTER -- requirements
Module: mult_requester

---
 rtl/mult_requester.sv | 150 +++++++++++++++
 tb/tb_mult_requester.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_requester.sv
// Operand latch and request/response sequencer for an external multiplier.
// Bounded wait for the completion strobe, with a sticky timeout flag.
module mult_requester #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   sw_in,
  input  logic               load_a,
  input  logic               load_b,
  input  logic               start,
  input  logic               clear_err,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               mult_valid,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_product,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [2*WIDTH-1:0] result_r;
  logic               mult_valid_r;
  logic               result_valid_r;
  logic               busy_r;
  logic               error_r;
  logic               capture_s;

  assign capture_s = (state_r == WAIT) && mult_done;

  // Next-state decode; completion wins over the timeout in the final wait cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if (mult_done) begin
          next_state_s = IDLE;
        end else if (wait_cnt_r == LAST_CNT) begin
          next_state_s = ERROR;
        end else begin
          next_state_s = WAIT;
        end
      end
      ERROR: begin
        if (clear_err) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ERROR;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand capture (IDLE only), wait counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      result_r   <= {(2*WIDTH){1'b0}};
      wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r == IDLE) && load_a) begin
        op_a_r <= sw_in;
      end
      if ((state_r == IDLE) && load_b) begin
        op_b_r <= sw_in;
      end
      case (state_r)
        REQ: begin
          wait_cnt_r <= {CNT_W{1'b0}};
        end
        WAIT: begin
          if (!mult_done) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          wait_cnt_r <= wait_cnt_r;
        end
      endcase
      if (capture_s) begin
        result_r <= mult_product;
      end
    end
  end

  // Status outputs are registered from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mult_valid_r   <= 1'b0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      error_r        <= 1'b0;
    end else begin
      mult_valid_r   <= (next_state_s == REQ);
      result_valid_r <= capture_s;
      busy_r         <= (next_state_s == REQ) || (next_state_s == WAIT);
      error_r        <= (next_state_s == ERROR);
    end
  end

  assign op_a         = op_a_r;
  assign op_b         = op_b_r;
  assign result       = result_r;
  assign mult_valid   = mult_valid_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign error        = error_r;

endmodule

// File: tb/tb_mult_requester.sv
// Directed self-checking bench for mult_requester (WIDTH=8, TIMEOUT=16).
module tb_mult_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw_in;
  logic        load_a, load_b, start, clear_err;
  logic [7:0]  op_a, op_b;
  logic        mult_valid;
  logic        mult_done;
  logic [15:0] mult_product;
  logic [15:0] result;
  logic        result_valid, busy, error;

  int checks = 0;
  int errors = 0;
  int mv_cnt, bz_cnt, rv_cnt;

  mult_requester #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .load_a(load_a), .load_b(load_b),
    .start(start), .clear_err(clear_err), .op_a(op_a), .op_b(op_b),
    .mult_valid(mult_valid), .mult_done(mult_done), .mult_product(mult_product),
    .result(result), .result_valid(result_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sw_in = 8'd0; load_a = 1'b0; load_b = 1'b0; start = 1'b0;
    clear_err = 1'b0; mult_done = 1'b0; mult_product = 16'd0;
    tick();
    tick();
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mv", 32'(mult_valid), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // Basic product 12*11, done in the 9th WAIT cycle; ignored inputs mid-WAIT
    sw_in = 8'd12; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk("load_a", 32'(op_a), 32'd12);
    sw_in = 8'd11; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    chk("load_b", 32'(op_b), 32'd11);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("req_mv", 32'(mult_valid), 32'd1);
    chk("req_op_a", 32'(op_a), 32'd12);
    chk("req_op_b", 32'(op_b), 32'd11);
    mv_cnt = 0; bz_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      mv_cnt += int'(mult_valid);
      bz_cnt += int'(busy);
      rv_cnt += int'(result_valid);
      if (i == 5) chk("wait_op_a_held", 32'(op_a), 32'd12);
      if (i == 10) chk("rv_latency", 32'(result_valid), 32'd1);
      if (i == 3) begin
        start = 1'b1; load_a = 1'b1; sw_in = 8'hFF;
      end else begin
        start = 1'b0; load_a = 1'b0;
      end
      mult_done = (i == 9);
      mult_product = (i == 9) ? 16'd132 : 16'hDEAD;
      tick();
    end
    mult_done = 1'b0;
    chk("basic_mv_pulses", 32'(mv_cnt), 32'd1);
    chk("basic_busy_cycles", 32'(bz_cnt), 32'd10);
    chk("basic_rv_pulses", 32'(rv_cnt), 32'd1);
    chk("basic_result", 32'(result), 32'd132);
    chk("basic_op_a", 32'(op_a), 32'd12);

    // Timeout after 16 WAIT cycles, start/done ignored in ERROR, then clear
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_req_mv", 32'(mult_valid), 32'd1);
    for (int i = 0; i < 16; i++) tick();
    chk("to_wait16_busy", 32'(busy), 32'd1);
    chk("to_wait16_error", 32'(error), 32'd0);
    tick();
    chk("to_error", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    start = 1'b1; mult_done = 1'b1; mult_product = 16'hBEEF;
    tick();
    start = 1'b0; mult_done = 1'b0;
    chk("err_start_mv", 32'(mult_valid), 32'd0);
    chk("err_start_busy", 32'(busy), 32'd0);
    chk("err_sticky", 32'(error), 32'd1);
    tick();
    chk("err_done_rv", 32'(result_valid), 32'd0);
    chk("err_done_result", 32'(result), 32'd132);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("clr_error", 32'(error), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    sw_in = 8'd3; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk("clr_idle_load", 32'(op_a), 32'd3);

    // Done coincides with the timeout cycle: capture wins
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("col_busy", 32'(busy), 32'd1);
    mult_done = 1'b1; mult_product = 16'h1234;
    tick();
    mult_done = 1'b0;
    chk("col_rv", 32'(result_valid), 32'd1);
    chk("col_result", 32'(result), 32'h1234);
    chk("col_error", 32'(error), 32'd0);
    chk("col_busy_after", 32'(busy), 32'd0);
    tick();
    chk("col_rv_once", 32'(result_valid), 32'd0);
    chk("col_error_after", 32'(error), 32'd0);

    // Same-cycle load and start, then reset while waiting
    sw_in = 8'd5; load_a = 1'b1; start = 1'b1;
    tick();
    load_a = 1'b0; start = 1'b0;
    chk("ls_mv", 32'(mult_valid), 32'd1);
    chk("ls_op_a", 32'(op_a), 32'd5);
    tick();
    tick();
    chk("rw_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_op_a", 32'(op_a), 32'd0);
    chk("rw_result", 32'(result), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_mv", 32'(mult_valid), 32'd0);
    chk("rw_rv", 32'(result_valid), 32'd0);
    mult_done = 1'b1; mult_product = 16'hFFFF;
    tick();
    mult_done = 1'b0;
    chk("rw_done_rv", 32'(result_valid), 32'd0);
    chk("rw_done_result", 32'(result), 32'd0);
    tick();
    chk("rw_done_rv2", 32'(result_valid), 32'd0);
    chk("rw_done_busy", 32'(busy), 32'd0);
    chk("rw_done_error", 32'(error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
